// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared types and op-decode helpers for the otter_muldiv
//                multiply/divide unit (RV32M funct3 encodings, FSM states).
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } muldiv_state_e;

    // Divide and remainder ops all have funct3[2] set
    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // Remainder ops are the divide ops with funct3[1] set
    function automatic logic is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_div_step
//  Description : One combinational restoring-divide step. Shifts the next
//                dividend bit into the partial remainder and subtracts the
//                divisor when it fits, producing one quotient bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_msb,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem_next,
    output logic             o_q_bit
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;

    // The partial remainder is always below the divisor, so the shifted value fits in WIDTH+1 bits
    assign w_shift    = {i_rem, i_msb};
    assign w_diff     = {1'b0, w_shift} - {2'b00, i_divisor};
    assign o_q_bit    = ~w_diff[WIDTH+1];
    assign o_rem_next = o_q_bit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/otter_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : otter_muldiv
//  Description : Multi-cycle RV32M multiply/divide unit. Iterative shift-add
//                multiply and restoring divide over operand magnitudes, with
//                sign correction on the way out and a one-cycle done pulse.
//                WIDTH must be even and at least 4.
//  Config      : OTTER_MULDIV_FAST_MUL_EN - single-cycle combinational
//                multiplier for MUL* ops; divides stay iterative.
//  Revision    : 1.0 - initial release
// ============================================================================
module otter_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             kill,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int               CNT_W  = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_min  = {1'b1, {(WIDTH-1){1'b0}}};

    muldiv_state_e      r_state;
    muldiv_state_e      w_state_next;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_result;
    logic               r_neg;
    logic               r_done;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_neg_in;
    logic               w_b_zero;
    logic               w_ovf;
    logic               w_fast_div;
    logic               w_fast_mul;
    logic [2*WIDTH-1:0] w_fast_prod;
    logic               w_accept;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH-1:0]   w_rem_next;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_prod_mag;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_final;

    // Operand decode: signs, magnitudes and the sign of the final result
    assign w_sa     = is_signed_a(op) & src_a[WIDTH-1];
    assign w_sb     = is_signed_b(op) & src_b[WIDTH-1];
    assign w_a_mag  = w_sa ? -src_a : src_a;
    assign w_b_mag  = w_sb ? -src_b : src_b;
    assign w_neg_in = is_rem(op) ? w_sa : (w_sa ^ w_sb);

    // Divide-by-zero and signed overflow are resolved without iterating
    assign w_b_zero   = (src_b == '0);
    assign w_ovf      = ((op == OP_DIV) || (op == OP_REM)) && (src_a == c_min) && (src_b == '1);
    assign w_fast_div = is_div(op) && (w_b_zero || w_ovf);
    assign w_accept   = (r_state == ST_IDLE) && start && !kill;

`ifdef OTTER_MULDIV_FAST_MUL_EN
    assign w_fast_mul  = !is_div(op);
    assign w_fast_prod = {{WIDTH{1'b0}}, w_a_mag} * {{WIDTH{1'b0}}, w_b_mag};
`else
    assign w_fast_mul  = 1'b0;
    assign w_fast_prod = '0;
`endif

    // Shift-add step: r_lo holds the remaining multiplier bits, r_hi the running high half
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

    muldiv_div_step #(
        .WIDTH      (WIDTH)
    ) u_div_step (
        .i_rem      (r_hi),
        .i_msb      (r_lo[WIDTH-1]),
        .i_divisor  (r_b),
        .o_rem_next (w_rem_next),
        .o_q_bit    (w_qbit)
    );

    // Sign correction: r_hi is remainder / product high, r_lo is quotient / product low
    assign w_prod_mag = {r_hi, r_lo};
    assign w_prod     = r_neg ? -w_prod_mag : w_prod_mag;
    assign w_final    = is_div(r_op) ? (is_rem(r_op) ? (r_neg ? -r_hi : r_hi)
                                                     : (r_neg ? -r_lo : r_lo))
                                     : ((r_op == OP_MUL) ? w_prod[WIDTH-1:0]
                                                         : w_prod[2*WIDTH-1:WIDTH]);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state and busy decode
    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = (w_fast_div || w_fast_mul) ? ST_FIN : ST_CALC;
            ST_CALC: if (kill) w_state_next = ST_IDLE;
                     else if (r_cnt == c_last) w_state_next = ST_FIN;
            ST_FIN:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: operand latch, one iteration per CALC cycle, result register and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op  <= op;
                        r_cnt <= '0;
                        r_b   <= w_b_mag;
                        if (w_fast_div) begin
                            r_hi  <= w_b_zero ? src_a : '0;
                            r_lo  <= w_b_zero ? '1 : c_min;
                            r_neg <= 1'b0;
                        end else if (w_fast_mul) begin
                            {r_hi, r_lo} <= w_fast_prod;
                            r_neg        <= w_neg_in;
                        end else begin
                            r_hi  <= '0;
                            r_lo  <= w_a_mag;
                            r_neg <= w_neg_in;
                        end
                    end
                end
                ST_CALC: begin
                    if (!kill) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (is_div(r_op)) begin
                            r_hi <= w_rem_next;
                            r_lo <= {r_lo[WIDTH-2:0], w_qbit};
                        end else begin
                            r_hi <= w_mul_sum[WIDTH:1];
                            r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
                        end
                    end
                end
                ST_FIN: begin
                    if (!kill) begin
                        r_result <= w_final;
                        r_done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done   = r_done;
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_otter_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_otter_muldiv
//  Description : Directed self-checking bench for otter_muldiv (WIDTH=32).
//  Config      : OTTER_MULDIV_FAST_MUL_EN changes the expected MUL* latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_otter_muldiv;
    import muldiv_pkg::*;

    localparam int WIDTH = 32;
`ifdef OTTER_MULDIV_FAST_MUL_EN
    localparam int c_mul_lat = 1;
`else
    localparam int c_mul_lat = WIDTH + 1;
`endif
    localparam int c_div_lat  = WIDTH + 1;
    localparam int c_fast_lat = 1;

    logic             clk;
    logic             rst;
    logic             start;
    logic             kill;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    int checks;
    int errors;

    otter_muldiv #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .kill   (kill),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present an op at the next negedge; returns just after the accepting edge N
    task automatic issue(input logic [2:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Wait for done (bounded); optionally pokes a start pulse at cycle 'poke' to show it is ignored
    task automatic wait_done(input int poke, output int lat, output logic busy_before, output logic busy_at);
        logic prev;
        lat = -1; busy_before = 1'b0; busy_at = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            if (i == poke) begin
                start = 1'b1; op = OP_MUL; src_a = 32'd3; src_b = 32'd3;
            end
            prev = busy;
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                lat = i; busy_before = prev; busy_at = busy;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp, input int exp_lat,
                          input int poke);
        int   lat;
        logic bb, ba;
        issue(o, a, b);
        wait_done(poke, lat, bb, ba);
        check_eq({tag, "_result"}, 64'(result), 64'(exp));
        check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_busy_before_done"}, 64'(bb), 64'd1);
        check_eq({tag, "_busy_at_done"}, 64'(ba), 64'd0);
        @(posedge clk); #1;
        check_eq({tag, "_done_single"}, 64'(done), 64'd0);
    endtask

    initial begin
        int   n_done;
        logic [WIDTH-1:0] held;
        checks = 0; errors = 0;
        rst = 1'b1; start = 1'b0; kill = 1'b0; op = '0; src_a = '0; src_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_done", 64'(done), 64'd0);
        check_eq("reset_result", 64'(result), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Multiply
        run_op("mul",        OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, c_mul_lat, 0);
        run_op("mulhu",      OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, c_mul_lat, 0);
        run_op("mulh",       OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, c_mul_lat, 0);
        run_op("mulhsu",     OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, c_mul_lat, 0);
        run_op("mulh_min",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, c_mul_lat, 0);
        run_op("mul_min",    OP_MUL,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000, c_mul_lat, 0);

        // Divide
        run_op("div_neg",    OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, c_div_lat, 0);
        run_op("rem_neg",    OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, c_div_lat, 0);
        run_op("divu",       OP_DIVU,   32'd100,       32'd7,         32'd14,        c_div_lat, 0);
        run_op("remu",       OP_REMU,   32'd100,       32'd7,         32'd2,         c_div_lat, 0);
        run_op("div_negb",   OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, c_div_lat, 0);
        run_op("rem_negb",   OP_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         c_div_lat, 0);

        // Fast paths
        run_op("divu_zero",  OP_DIVU,   32'h0000_1234, 32'h0,         32'hFFFF_FFFF, c_fast_lat, 0);
        run_op("rem_zero",   OP_REM,    32'h0000_1234, 32'h0,         32'h0000_1234, c_fast_lat, 0);
        run_op("div_ovf",    OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, c_fast_lat, 0);
        run_op("rem_ovf",    OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, c_fast_lat, 0);

        // Start held through the FIN cycle of a fast op must not launch a second op
        @(negedge clk);
        op = OP_DIVU; src_a = 32'h55; src_b = 32'h0; start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("fin_start_done", 64'(done), 64'd1);
        check_eq("fin_start_busy_at_done", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check_eq("fin_start_ignored", 64'(busy), 64'd0);

        // Start together with kill in IDLE is not accepted
        @(negedge clk);
        op = OP_DIVU; src_a = 32'd100; src_b = 32'd7; start = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        check_eq("start_kill_idle", 64'(busy), 64'd0);

        // Kill mid-divide: no done, result keeps the previous value
        held = result;
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check_eq("kill_busy", 64'(busy), 64'd0);
        check_eq("kill_done", 64'(done), 64'd0);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check_eq("kill_no_done", 64'(n_done), 64'd0);
        check_eq("kill_result_held", 64'(result), 64'(held));

        // New op accepted after kill; a start while busy is ignored
        run_op("divu_poke",  OP_DIVU,   32'd100,       32'd7,         32'd14,        c_div_lat, 5);

        // Reset mid-CALC clears everything
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rst_mid_busy", 64'(busy), 64'd0);
        check_eq("rst_mid_done", 64'(done), 64'd0);
        check_eq("rst_mid_result", 64'(result), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
